// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable first-word-fall-through read path.
module fifo_sync_ext #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          err_clr,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  generate
    if (DATA_WIDTH < 1) begin : g_bad_width
      $error("fifo_sync_ext: DATA_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fifo_sync_ext: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH - 1) begin : g_bad_afull
      $error("fifo_sync_ext: AFULL_THRESH out of range 1..FIFO_DEPTH-1");
    end
    if (AEMPTY_THRESH < 1 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
      $error("fifo_sync_ext: AEMPTY_THRESH out of range 1..FIFO_DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("fifo_sync_ext: FWFT must be 0 or 1");
    end
  endgenerate

  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] AFULL_C  = (AW + 1)'(AFULL_THRESH);
  localparam logic [AW:0] AEMPTY_C = (AW + 1)'(AEMPTY_THRESH);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  wr_acc;
  logic                  rd_acc;

  // Extra pointer MSB makes the difference the true occupancy, 0..FIFO_DEPTH.
  assign count        = wr_ptr_reg - rd_ptr_reg;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  assign wr_acc = cs && wr_en && !full;
  assign rd_acc = cs && rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_acc) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      // A new error in the same cycle as a clear takes priority.
      if (cs && wr_en && full)  overflow_reg <= 1'b1;
      else if (cs && err_clr)   overflow_reg <= 1'b0;
      if (cs && rd_en && empty) underflow_reg <= 1'b1;
      else if (cs && err_clr)   underflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg[AW-1:0]] <= data_in;
  end

  generate
    if (FWFT == 1) begin : g_fwft
      assign data_out = mem[rd_ptr_reg[AW-1:0]];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_reg;
      always_ff @(posedge clk) begin
        if (!rst_n)      data_reg <= '0;
        else if (rd_acc) data_reg <= mem[rd_ptr_reg[AW-1:0]];
      end
      assign data_out = data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Self-checking bench: a standard-read and an FWFT instance share stimulus and are
// compared against a queue-based occupancy model of the FIFO.
module tb_fifo_sync_ext;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cs = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] data_out, data_f;
  logic       empty, full, almost_full, almost_empty, overflow, underflow;
  logic       empty_f, full_f, afull_f, aempty_f, ovf_f, udf_f;
  logic [4:0] count, count_f;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];
  logic [7:0] m_dout = '0;
  logic       m_ovf = 1'b0, m_udf = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_ext #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(12),
                  .AEMPTY_THRESH(4), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .err_clr(err_clr), .data_out(data_out),
    .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow));

  fifo_sync_ext #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(12),
                  .AEMPTY_THRESH(4), .FWFT(1)) dut_fw (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .err_clr(err_clr), .data_out(data_f),
    .empty(empty_f), .full(full_f), .almost_full(afull_f),
    .almost_empty(aempty_f), .count(count_f),
    .overflow(ovf_f), .underflow(udf_f));

  // Drive one cycle, advance the model across the edge, return #1 after it.
  task automatic step(input logic w, input logic r, input logic [7:0] d,
                      input logic clr, input logic c);
    logic full_m, empty_m, wacc, racc;
    cs = c; wr_en = w; rd_en = r; data_in = d; err_clr = clr;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      full_m  = (mq.size() == 16);
      empty_m = (mq.size() == 0);
      wacc = c && w && !full_m;
      racc = c && r && !empty_m;
      if (c && w && full_m)     m_ovf = 1'b1;
      else if (c && clr)        m_ovf = 1'b0;
      if (c && r && empty_m)    m_udf = 1'b1;
      else if (c && clr)        m_udf = 1'b0;
      if (racc) m_dout = mq.pop_front();
      if (wacc) mq.push_back(d);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    do_reset();
    got = {empty, full, almost_full, almost_empty, overflow, underflow};
    n_checks++;
    if (got !== 6'b100100) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected %b", got, 6'b100100);
    end
    n_checks++;
    if (count !== 5'd0 || data_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_count_data: got %0d/%h, expected 0/00", count, data_out);
    end
    $display("reset: count=%0d empty=%b data_out=%h", count, empty, data_out);
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_d;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0, 1'b1);
      n_checks++;
      if (count !== 5'(i) || almost_empty !== (i <= 4) || almost_full !== (i >= 12)
          || full !== (i == 16) || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: got count=%0d ae=%b af=%b full=%b empty=%b, expected count=%0d ae=%b af=%b full=%b empty=0",
                 i, count, almost_empty, almost_full, full, empty, i, i <= 4, i >= 12, i == 16);
      end
      $display("write %h: count=%0d ae=%b af=%b full=%b", 8'(i), count, almost_empty, almost_full, full);
    end
    step(1'b1, 1'b0, 8'hAA, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_fail++; $display("FAIL overflow_set: got ovf=%b count=%0d, expected ovf=1 count=16", overflow, count);
    end
    $display("write AA while full: overflow=%b count=%0d", overflow, count);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL overflow_clr: got %b, expected 0", overflow);
    end
    for (int i = 1; i <= 16; i++) begin
      exp_d = 8'(i);
      n_checks++;
      if (data_f !== exp_d) begin
        n_fail++; $display("FAIL fwft_pre_pop_%0d: got %h, expected %h", i, data_f, exp_d);
      end
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (data_out !== exp_d || count !== 5'(16 - i)) begin
        n_fail++; $display("FAIL read_%0d: got data=%h count=%0d, expected data=%h count=%0d",
                           i, data_out, count, exp_d, 16 - i);
      end
      $display("read: data_out=%h count=%0d", data_out, count);
    end
    n_checks++;
    if (empty !== 1'b1 || empty_f !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty: got %b/%b, expected 1/1", empty, empty_f);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    n_checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rw_empty: got count=%0d udf=%b ovf=%b, expected count=1 udf=1 ovf=0",
                         count, underflow, overflow);
    end
    $display("rd+wr on empty: count=%0d underflow=%b", count, underflow);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    n_checks++;
    if (count !== 5'd15 || overflow !== 1'b1 || underflow !== 1'b0 || data_out !== 8'h33) begin
      n_fail++; $display("FAIL rw_full: got count=%0d ovf=%b udf=%b data=%h, expected count=15 ovf=1 udf=0 data=33",
                         count, overflow, underflow, data_out);
    end
    $display("rd+wr on full: count=%0d overflow=%b data_out=%h", count, overflow, data_out);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      step(1'b1, 1'b1, d, 1'b0, 1'b1);
      n_checks++;
      if (count !== 5'd8 || data_out !== m_dout || data_f !== mq[0]) begin
        n_fail++; $display("FAIL b2b_%0d: got count=%0d data=%h fwft=%h, expected count=8 data=%h fwft=%h",
                           i, count, data_out, data_f, m_dout, mq[0]);
      end
      $display("b2b wr %h: data_out=%h count=%0d", d, data_out, count);
    end
  endtask

  task automatic test_fwft();
    do_reset();
    step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1);
    n_checks++;
    if (data_f !== 8'h5A || empty_f !== 1'b0) begin
      n_fail++; $display("FAIL fwft_write: got data=%h empty=%b, expected data=5a empty=0", data_f, empty_f);
    end
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (empty_f !== 1'b1 || count_f !== 5'd0) begin
      n_fail++; $display("FAIL fwft_pop: got empty=%b count=%0d, expected empty=1 count=0", empty_f, count_f);
    end
    $display("fwft: write 5a then pop, empty=%b", empty_f);
  endtask

  task automatic test_cs_and_midreset();
    logic [7:0] held;
    do_reset();
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h90 + i), 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    held = data_out;
    for (int i = 0; i < 12; i++)
      step(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    n_checks++;
    if (count !== 5'd9 || data_out !== held || underflow !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL cs_idle: got count=%0d data=%h udf=%b ovf=%b, expected count=9 data=%h udf=1 ovf=0",
                         count, data_out, underflow, overflow, held);
    end
    $display("cs=0 idle: count=%0d data_out=%h underflow=%b", count, data_out, underflow);
    do_reset();
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || data_out !== 8'h00 || underflow !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL midreset: got count=%0d empty=%b data=%h udf=%b ovf=%b, expected 0 1 00 0 0",
                         count, empty, data_out, underflow, overflow);
    end
  endtask

  task automatic test_random();
    logic [5:0] exp_f, got_f;
    int pw, pr;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pw = ((i / 50) % 2 == 0) ? 75 : 25;
      pr = 100 - pw;
      step(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr), 8'($urandom),
           1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) < 90));
      exp_f = {mq.size() == 0, mq.size() == 16, mq.size() >= 12, mq.size() <= 4, m_ovf, m_udf};
      got_f = {empty, full, almost_full, almost_empty, overflow, underflow};
      n_checks++;
      if (got_f !== exp_f || count !== 5'(mq.size()) || count_f !== 5'(mq.size()) || data_out !== m_dout
          || (mq.size() != 0 && data_f !== mq[0])) begin
        n_fail++; $display("FAIL rand_%0d: got flags=%b count=%0d data=%h fwft=%h, expected flags=%b count=%0d data=%h",
                           i, got_f, count, data_out, data_f, exp_f, mq.size(), m_dout);
      end
      $display("rand %0d: cs=%b wr=%b rd=%b count=%0d data_out=%h", i, cs, wr_en, rd_en, count, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_back_to_back();
    test_fwft();
    test_cs_and_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_ext.md
# fifo_sync_ext

Parametrised single-clock FIFO, the successor to the basic synchronous FIFO. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain and is a drop-in replacement wherever the basic FIFO's cs/wr_en/rd_en handshake is used.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- FIFO_DEPTH, 16, number of entries; power of 2, ≥2
- AFULL_THRESH, 12, almost_full asserts at count ≥ this; range 1..FIFO_DEPTH-1
- AEMPTY_THRESH, 4, almost_empty asserts at count ≤ this; range 1..FIFO_DEPTH-1
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- Any out-of-range parameter value is an elaboration error.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- cs  in  1  chip select; when 0, the block ignores wr_en, rd_en and err_clr
- wr_en  in  1  write request
- rd_en  in  1  read request (pop)
- data_in  in  DATA_WIDTH  write data
- err_clr  in  1  clears overflow and underflow
- data_out  out  DATA_WIDTH  read data
- empty  out  1  count == 0
- full  out  1  count == FIFO_DEPTH
- almost_full  out  1  count ≥ AFULL_THRESH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty. The low bits index memory and wrap naturally.
- Write accepted: cs && wr_en && !full. Data is stored at wr_ptr and wr_ptr increments.
- Read accepted: cs && rd_en && !empty. rd_ptr increments.
- Accept/reject decisions use the flag values before the edge. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- Count update per cycle:
  - write and read both accepted: count unchanged
  - write only: count +1
  - read only: count −1
  - count never exceeds FIFO_DEPTH and never goes below 0.
- All flags are decoded combinationally from registered count/pointers, so there is no extra pipeline delay.
- FWFT=0: data_out is a register. It loads mem[rd_ptr] on the edge where a read is accepted and holds otherwise.
- FWFT=1: data_out = mem[rd_ptr] combinationally. It is valid whenever empty=0 and undefined when empty=1. An accepted read pops the presented word.
- overflow sets on cs && wr_en && full; underflow sets on cs && rd_en && empty.
  - Both stay set until cleared by cs && err_clr, or by reset.
  - If a set and a clear occur in the same cycle, the set wins.
- Rejected operations change no pointer, count or memory content.

## Timing
- Reset (rst_n=0 sampled at a rising edge): pointers=0, count=0, data_out=0, overflow=0, underflow=0. Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0.
- Memory contents are not reset. Reset mid-operation discards all stored words, and the flags reflect an empty FIFO from the edge that samples reset.
- Write latency: a word written at edge N is counted, and moves the flags, after edge N.
  - FWFT=1: a word written into an empty FIFO appears on data_out after edge N.
- Read latency:
  - FWFT=0: data is on data_out one cycle after the accepting edge, i.e. valid after edge N when rd_en is sampled at edge N.
  - FWFT=1: data is valid before the pop, in the same cycle rd_en is asserted.
- Throughput: one write and one read per cycle, sustained, at any occupancy where both are accepted.

## Test plan
- Reset, then write 16 words 0x01..0x10 with FIFO_DEPTH=16 → count steps 1..16; almost_empty drops when count goes 4→5; almost_full rises at 12; full=1 at 16. Then read 16 (FWFT=0) → data_out 0x01..0x10, each one cycle after its rd_en edge; empty=1 at end.
- Full FIFO, one extra write of 0xAA → rejected, overflow=1, count=16, contents unchanged. Then cs=1 with err_clr=1 → overflow=0 next cycle.
- Empty FIFO with rd_en=1 and wr_en=1 in the same cycle → write accepted, read rejected, underflow=1, count=1. Repeat with the FIFO full → read accepted, write rejected, overflow=1, count=15.
- Count=8, 20 cycles of simultaneous read+write → count stays 8 and output order is preserved; the pointers wrap past 16 without error.
- FWFT=1: write 0x5A into an empty FIFO → data_out=0x5A and empty=0 after that edge. Pop → empty=1.
- Hold cs=0 with wr_en/rd_en/err_clr toggling → no change in count, data_out or flags. Assert rst_n=0 at count=9 → after the edge count=0, empty=1, data_out=0, error flags 0.
